// File: rtl/flash_pkg.sv
// Shared constants and types for the byte-wide flash responder slice.
package flash_pkg;

   localparam int FLASH_ADDR_W = 24;
   localparam int DATA_W       = 8;
   localparam int READ_LAT_DEF = 3;

   localparam logic [DATA_W-1:0] ERASED_BYTE = 8'hFF;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_e;

endpackage

// File: rtl/flash_responder_if.sv
// Byte-wide flash bus: the initiator drives requests, the responder returns data and status.
interface flash_responder_if
   import flash_pkg::*;
#(
   parameter int ADDR_W = FLASH_ADDR_W
);

   logic              cs;
   logic              we;
   logic              re;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] in;
   logic [DATA_W-1:0] out;
   logic              out_valid;
   logic              busy;
   logic              err;

   modport master (
      output cs, we, re, addr, in,
      input  out, out_valid, busy, err
   );

   modport slave (
      input  cs, we, re, addr, in,
      output out, out_valid, busy, err
   );

endinterface

// File: rtl/flash_byte_array.sv
// DEPTH x 8 storage: synchronous write, combinational read, deliberately never reset.
module flash_byte_array
   import flash_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/flash_responder.sv
// Flash bus responder: single-byte writes, fixed-latency reads, busy/valid/err status.
module flash_responder
   import flash_pkg::*;
#(
   parameter int ADDR_W   = FLASH_ADDR_W,
   parameter int DEPTH    = 256,
   parameter int READ_LAT = READ_LAT_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   flash_responder_if.slave   bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = 3;

   localparam logic [0:0] S_IDLE    = 1'(IDLE);
   localparam logic [0:0] S_RD_WAIT = 1'(RD_WAIT);

   localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(READ_LAT - 1);

   // Full-width compare so high address bits can never alias into the array.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_EXT);
   endfunction

   logic [0:0]        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
   logic [DATA_W-1:0] out_q, out_nxt;
   logic              vld_q, vld_nxt;
   logic              err_q, err_nxt;
   logic              done;
   logic              accepting;
   logic              wr_en;
   logic [DATA_W-1:0] rd_data;

   flash_byte_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (bus.addr[IDX_W-1:0]),
      .wr_data (bus.in),
      .rd_addr (lat_addr[IDX_W-1:0]),
      .rd_data (rd_data)
   );

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      lat_addr_nxt = lat_addr;
      out_nxt      = out_q;
      vld_nxt      = 1'b0;
      err_nxt      = 1'b0;
      wr_en        = 1'b0;

      done      = (state == S_RD_WAIT) && (cnt == '0);
      accepting = (state == S_IDLE) || done;

      if (state == S_RD_WAIT) begin
         if (done) begin
            out_nxt   = in_range(lat_addr) ? rd_data : ERASED_BYTE;
            vld_nxt   = 1'b1;
            err_nxt   = !in_range(lat_addr);
            state_nxt = S_IDLE;
         end else begin
            cnt_nxt = cnt - 1'b1;
            if (bus.cs && (bus.we || bus.re)) begin
               err_nxt = 1'b1;
            end
         end
      end

      // The completion edge re-enters IDLE, so a new request is served there too.
      if (accepting && bus.cs) begin
         if (bus.we) begin
            if (in_range(bus.addr)) begin
               wr_en = 1'b1;
            end else begin
               err_nxt = 1'b1;
            end
         end else if (bus.re) begin
            lat_addr_nxt = bus.addr;
            cnt_nxt      = CNT_LOAD;
            state_nxt    = S_RD_WAIT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         lat_addr <= '0;
         out_q    <= '0;
         vld_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         lat_addr <= lat_addr_nxt;
         out_q    <= out_nxt;
         vld_q    <= vld_nxt;
         err_q    <= err_nxt;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = vld_q;
   assign bus.busy      = (state == S_RD_WAIT);
   assign bus.err       = err_q;

endmodule

// File: doc/flash_responder.md
# flash_responder

Memory-side responder for the byte-wide flash bus (`cs`/`we`/`re`/`addr`/`in`/`out`) that the fetch path and program loader drive. It accepts single-byte writes and single-byte reads and returns read data after a fixed latency. It also reports busy, valid and error status, so hardware fetch logic can sequence accesses without fixed-delay guesses. It sits between the bus initiator (loader/fetch sequencer) and the byte storage array.

## Interface
Parameters:
- `ADDR_W`, default 24: bus address width.
- `DEPTH`, default 256: implemented bytes. Addresses at or above `DEPTH` are out of range.
- `READ_LAT`, default 3: cycles from read accept to data valid. Legal range 1–7.

Ports:
- `clk`, in, 1: single clock. All logic updates on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `cs`, in, 1: chip select. Requests are sampled only when `cs` = 1.
- `we`, in, 1: write request.
- `re`, in, 1: read request.
- `addr`, in, `ADDR_W`: byte address.
- `in`, in, 8: write data.
- `out`, out, 8: read data. Held until the next read completes.
- `out_valid`, out, 1: one-cycle pulse when `out` carries new read data.
- `busy`, out, 1: high while a read is in flight. Requests are not accepted while high.
- `err`, out, 1: one-cycle pulse on a dropped or out-of-range request.

## Operation
- Reset values: `out` = 8'h00, `out_valid` = 0, `busy` = 0, `err` = 0, state IDLE, latency counter 0.
- Reset does not clear the storage array, because contents persist like flash. Unwritten locations read X in simulation.
- FSM states:
  - IDLE:
    - On a clock edge with `cs` & `we`: write request. `we` has priority if `re` is also high.
    - If the write is in range: `mem[addr]` <= `in`. Stay in IDLE.
    - If the write is out of range: drop the data and pulse `err`.
  - IDLE, read accept:
    - On a clock edge with `cs` & `re` & !`we`: latch `addr`, load counter = `READ_LAT` − 1, go to RD_WAIT, set `busy` = 1.
  - RD_WAIT:
    - Counter decrements each cycle.
    - When the counter reaches 0: `out` <= `mem[latched addr]`, or 8'hFF if out of range with an `err` pulse. Pulse `out_valid`, clear `busy`, return to IDLE.
  - RD_WAIT, other requests:
    - Any `cs` & (`we` | `re`) during RD_WAIT is ignored and pulses `err`. The write is dropped and the memory is unchanged.
- Once a read is accepted it completes regardless of later `cs`/`re`/`addr` changes.
- `cs` = 0, or `cs` = 1 with `we` = `re` = 0: no action.
- Address compare uses the full `ADDR_W` bits. Storage is indexed by `addr[$clog2(DEPTH)-1:0]` only after the range check passes.

## Timing
- Write: one-cycle accept. Data is visible to a read accepted on the next edge.
- Read: accept edge T0. `out` and `out_valid` update at edge T0 + `READ_LAT`. `busy` is high from T0 through T0 + `READ_LAT`, falling at that edge.
- Back-to-back reads: the next read can be accepted at edge T0 + `READ_LAT`, because IDLE is re-entered there. The peak rate is one byte per `READ_LAT` cycles.
- `err` fires on the same edge as the offending request, or on the completion edge for an out-of-range read.
- `rst_n` low mid-read:
  - Immediately abort and go to IDLE.
  - Outputs take their reset values.
  - No `out_valid` is produced for the aborted read.

## Structure
- Shared package `flash_pkg`:
  - `ADDR_W` and data width 8.
  - State enum {IDLE, RD_WAIT}.
  - `ERASED_BYTE` = 8'hFF.
  - `READ_LAT` default.
- Sub-module `flash_byte_array`: `DEPTH` × 8 storage with synchronous write and combinational read, no reset. The FSM, counter and range checks live in `flash_responder`.

## Test plan
- Write 32'h02000283 little-endian to addresses 0–3, then read addresses 0–3 sequentially.
  - Required: `out` = 8'h83, 8'h02, 8'h00, 8'h02.
  - Each byte arrives exactly 3 cycles after its accept, with a one-cycle `out_valid`.
- Read address 0, and during RD_WAIT issue a write of 8'hAA to address 0 with a read of address 4.
  - Required: `err` pulses for the write and pulses for the read.
  - The first read still returns 8'h83, and `mem[0]` is unchanged.
- Read address 24'h000100 (out of range with `DEPTH` = 256).
  - Required: `out` = 8'hFF and `err` pulse at T0 + 3.
  - A write to 24'h000100 pulses `err` and does not alias to address 0.
- Assert `cs`, `we` and `re` together with address 0x10 and data 8'h01.
  - Required: write wins, with no read accepted (`busy` stays 0).
  - A following read of 0x10 returns 8'h01.
- Accept a read, then drop `rst_n` one cycle later.
  - Required: `busy`, `out` and `out_valid` go to 0 immediately, with no later `out_valid`.
  - After release, a read of address 1 returns the previously written 8'h02, proving storage is retained.
